// File: rtl/mem_bus_pkg.sv
// Shared types for the CPU memory arbiter.
// Arbiter state encoding and the full-word byte-enable constant.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } arb_state_e;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_port_buffer.sv
// Completion flag and response word for one CPU memory port.
// Ports: clk_i, rst_i, set_i (complete), clr_i (advance), data_i -> done_o, rdata_o.
module mem_port_buffer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        set_i,
  input  logic        clr_i,
  input  logic [31:0] data_i,
  output logic        done_o,
  output logic [31:0] rdata_o
);

  logic        done_q;
  logic        done_d;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    done_d  = done_q;
    rdata_d = rdata_q;
    if (clr_i) begin
      done_d = 1'b0;
    end
    if (set_i) begin
      done_d  = 1'b1;
      rdata_d = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign done_o  = done_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU fetch and data ports onto one memory bus (data first).
// Ports: CPU instr/data ports, mem_* bus, err_o timeout pulse, stall_cnt_o.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             instr_mem_rd_i,
  input  logic [31:0]      instr_mem_addr_i,
  output logic [31:0]      instr_mem_data_o,
  output logic             instr_mem_ready_o,
  input  logic             data_mem_rd_i,
  input  logic             data_mem_wr_i,
  input  logic [31:0]      data_mem_addr_i,
  input  logic [31:0]      data_mem_data_i,
  input  logic [3:0]       byte_select_i,
  output logic [31:0]      data_mem_data_o,
  output logic             data_mem_ready_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic [3:0]       mem_be_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_ack_i,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [WW-1:0]    wait_q;
  logic [WW-1:0]    wait_d;
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;

  logic        data_req;
  logic        instr_done;
  logic        data_done;
  logic        advance;
  logic        timeout;
  logic        instr_set;
  logic        data_set;
  logic [31:0] instr_fill;
  logic [31:0] data_fill;

  assign data_req = data_mem_rd_i | data_mem_wr_i;

  assign instr_mem_ready_o = !instr_mem_rd_i | instr_done;
  assign data_mem_ready_o  = !data_req | data_done;
  assign advance = instr_mem_ready_o & data_mem_ready_o;

  // Timed-out transactions and stores return a zero word.
  assign instr_fill = timeout ? 32'h0 : mem_rdata_i;
  assign data_fill  = (timeout | data_mem_wr_i) ? 32'h0 : mem_rdata_i;

  mem_port_buffer u_instr_buf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .set_i  (instr_set),
    .clr_i  (advance),
    .data_i (instr_fill),
    .done_o (instr_done),
    .rdata_o(instr_mem_data_o)
  );

  mem_port_buffer u_data_buf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .set_i  (data_set),
    .clr_i  (advance),
    .data_i (data_fill),
    .done_o (data_done),
    .rdata_o(data_mem_data_o)
  );

  // A pending, unfinished request implies !advance, so
  // nothing is ever started in an advance cycle.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    err_d     = 1'b0;
    timeout   = 1'b0;
    instr_set = 1'b0;
    data_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_req && !data_done) begin
          state_d = DATA;
        end else if (instr_mem_rd_i && !instr_done) begin
          state_d = INSTR;
        end
      end
      DATA, INSTR: begin
        timeout = !mem_ack_i && (wait_q == WAIT_LAST);
        if (mem_ack_i || timeout) begin
          state_d   = IDLE;
          err_d     = timeout;
          data_set  = (state_q == DATA);
          instr_set = (state_q == INSTR);
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    mem_be_o    = 4'h0;
    if (state_q == DATA) begin
      mem_req_o  = 1'b1;
      mem_we_o   = data_mem_wr_i;
      mem_addr_o = data_mem_addr_i;
      if (data_mem_wr_i) begin
        mem_wdata_o = data_mem_data_i;
        mem_be_o    = byte_select_i;
      end else begin
        mem_be_o = BE_ALL;
      end
    end else if (state_q == INSTR) begin
      mem_req_o  = 1'b1;
      mem_addr_o = instr_mem_addr_i;
      mem_be_o   = BE_ALL;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!advance && !(&stall_q)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_q;

endmodule
